usb_xact_ctrl: RTL and testbench
================================

Name: usb_xact_ctrl

Overview:
- Device-side USB transaction sequencer between the AHB-Lite slave registers and the usb_rx / usb_tx / databuffer datapath.
- Decodes token packets reported by usb_rx and issues the matching response packet to usb_tx:
  - DATA for IN, ACK/NAK for OUT.
- Tracks completion, timeouts and errors, and reports per-transaction status back to software.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles to wait for a tx start, an OUT data packet, or a host ACK before aborting.
- MAX_PKT_BYTES, 64: maximum payload; buffer_occupancy above this on OUT data is an error.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- rx_packet  in  4  packet type decoded by usb_rx (usb_xact_pkg encoding)
- rx_data_ready  in  1  one-cycle strobe: rx_packet valid, packet complete
- rx_error  in  1  usb_rx error flag (level)
- tx_trans_active  in  1  usb_tx sending a packet
- tx_error  in  1  usb_tx error flag
- buffer_occupancy  in  7  databuffer byte count, 0..64
- rx_arm  in  1  one-cycle pulse: software ready to accept an OUT payload
- tx_arm  in  1  one-cycle pulse: software loaded an IN payload
- abort  in  1  one-cycle pulse: disarm both directions, return to IDLE
- tx_packet  out  4  one-cycle request to usb_tx, TX_NONE otherwise
- clear  out  1  one-cycle databuffer flush request
- rx_done  out  1  one-cycle pulse: OUT payload accepted and ACKed
- tx_done  out  1  one-cycle pulse: IN payload ACKed by host
- xact_err  out  1  one-cycle pulse: timeout, rx/tx error, or oversize
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset:
  - Async on n_rst low. State IDLE, rx_armed = tx_armed = 0, timer 0.
  - All outputs 0 (tx_packet = TX_NONE). A reset mid-operation drops the transaction silently.
- Arm flags:
  - rx_arm / tx_arm set the corresponding flag; abort clears both.
  - Arm and auto-clear in the same cycle: arm wins. Arm and abort in the same cycle: abort wins.
- Timer:
  - Cleared on every state entry; increments while in any wait state.
  - Reaching TIMEOUT_CYCLES-1 -> xact_err pulse, go to IDLE.
- IDLE:
  - Acts only on rx_data_ready.
  - OUT: go to WAIT_OUT_DATA.
  - IN: if tx_armed, go to SEND, code TX_DATA; else go to SEND, code TX_NAK.
  - Any other type: ignored.
- WAIT_OUT_DATA:
  - rx_data_ready with DATA and rx_error = 0:
    - If rx_armed and occupancy <= MAX_PKT_BYTES: SEND, code TX_ACK, rx_done pulse, rx_armed cleared.
    - If not armed: SEND, code TX_NAK, plus clear pulse.
    - If oversize: clear pulse, xact_err pulse, IDLE with no handshake.
  - rx_error = 1 at the strobe: clear pulse, xact_err pulse, IDLE (no handshake, per USB).
  - Any other type: xact_err pulse, IDLE.
- SEND:
  - Drive tx_packet = latched code for exactly one cycle.
  - tx_packet asserts 1 cycle after the rx_data_ready strobe was sampled.
  - Next state: WAIT_TX_START.
- WAIT_TX_START:
  - tx_trans_active = 1 -> WAIT_TX_END.
  - Timeout -> xact_err pulse, IDLE.
- WAIT_TX_END:
  - tx_trans_active = 0 with tx_error = 0:
    - If code was TX_DATA -> WAIT_HOST_ACK.
    - Otherwise -> IDLE.
  - tx_error = 1 at any point: xact_err pulse, clear pulse, IDLE.
- WAIT_HOST_ACK:
  - rx_data_ready with ACK: tx_done pulse, tx_armed cleared, IDLE.
  - Other type, rx_error, or timeout: xact_err pulse, IDLE, tx_armed kept so the host retry resends the same data.
- rx_data_ready is ignored in SEND, WAIT_TX_START and WAIT_TX_END.
- abort in any state: IDLE next cycle, clear pulse, no xact_err.
- Pulse outputs are registered. At most one of rx_done / tx_done / xact_err is high per cycle.

Decomposition:
- Package usb_xact_pkg:
  - rx_packet encodings: RX_NONE = 0, RX_OUT = 1, RX_IN = 2, RX_DATA = 3, RX_ACK = 4, RX_NAK = 5.
  - tx_packet encodings: TX_NONE = 0, TX_DATA = 1, TX_ACK = 2, TX_NAK = 3.
  - State enum: IDLE, WAIT_OUT_DATA, SEND, WAIT_TX_START, WAIT_TX_END, WAIT_HOST_ACK.
- One sub-module, xact_timer: loadable counter with clear/enable and a terminal-count flag, parameterised by TIMEOUT_CYCLES.

Test Plan:
- OUT, armed: rx_arm; OUT strobe; DATA strobe with occupancy = 8.
  -> tx_packet = 2 for one cycle 1 cycle later; rx_done = 1. Emulate tx_trans_active for 20 cycles -> IDLE, busy = 0.
- OUT, not armed: OUT then DATA.
  -> tx_packet = 3 (NAK), clear pulse, no rx_done.
- IN, armed: tx_arm; IN strobe.
  -> tx_packet = 1; tx_active high then low; host ACK strobe -> tx_done pulse, tx_armed = 0. A second IN now -> tx_packet = 3.
- IN with no host ACK: after the DATA send, wait 1024 cycles.
  -> xact_err pulse at timeout, tx_armed still 1. Next IN -> tx_packet = 1 again.
- OUT data errors:
  - DATA strobe with rx_error = 1 -> clear + xact_err, tx_packet stays 0.
  - DATA strobe with occupancy = 65 -> same response.
- Abort and reset:
  - abort during WAIT_TX_END -> IDLE next cycle, clear pulse, no xact_err.
  - n_rst low during WAIT_HOST_ACK -> all outputs 0 immediately.

Source files
------------

// File: rtl/usb_xact_pkg.sv
// Shared encodings and state type for the USB device transaction sequencer.
package usb_xact_pkg;

  localparam int TIMEOUT_CYCLES_DEF = 1024;
  localparam int MAX_PKT_BYTES_DEF  = 64;

  typedef enum logic [3:0] {
    RX_NONE = 4'd0,
    RX_OUT  = 4'd1,
    RX_IN   = 4'd2,
    RX_DATA = 4'd3,
    RX_ACK  = 4'd4,
    RX_NAK  = 4'd5
  } rx_pkt_e;

  typedef enum logic [3:0] {
    TX_NONE = 4'd0,
    TX_DATA = 4'd1,
    TX_ACK  = 4'd2,
    TX_NAK  = 4'd3
  } tx_pkt_e;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    WAIT_OUT_DATA = 3'd1,
    SEND          = 3'd2,
    WAIT_TX_START = 3'd3,
    WAIT_TX_END   = 3'd4,
    WAIT_HOST_ACK = 3'd5
  } xact_state_e;

  // States bounded by the timeout: waiting on the host or on usb_tx to start.
  function automatic logic is_timed_state(input xact_state_e s);
    case (s)
      WAIT_OUT_DATA: is_timed_state = 1'b1;
      WAIT_TX_START: is_timed_state = 1'b1;
      WAIT_HOST_ACK: is_timed_state = 1'b1;
      default:       is_timed_state = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/usb_xact_ctrl_timer.sv
// Timeout counter: cleared on state entry, counts while enabled, flags terminal count.
module xact_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  // Cycle counter with synchronous clear taking priority over enable.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CW'(1);
    end else begin
      r_count <= r_count;
    end
  end

  // A stale count from the previous state must not fire on the entry cycle.
  assign o_tc = i_en & ~i_clear & (r_count == TC_VAL);

endmodule

// File: rtl/usb_xact_ctrl.sv
// Device-side USB transaction sequencer: token decode, handshake/data requests, status pulses.
module usb_xact_ctrl
  import usb_xact_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int MAX_PKT_BYTES  = MAX_PKT_BYTES_DEF
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [3:0] rx_packet,
  input  logic       rx_data_ready,
  input  logic       rx_error,
  input  logic       tx_trans_active,
  input  logic       tx_error,
  input  logic [6:0] buffer_occupancy,
  input  logic       rx_arm,
  input  logic       tx_arm,
  input  logic       abort,
  output logic [3:0] tx_packet,
  output logic       clear,
  output logic       rx_done,
  output logic       tx_done,
  output logic       xact_err,
  output logic       busy
);

  xact_state_e r_state, r_prev_state;
  tx_pkt_e     r_code, r_tx_packet;
  logic        r_rx_armed, r_tx_armed;
  logic        r_clear, r_rx_done, r_tx_done, r_xact_err;
  logic        w_tmr_clr, w_tmr_en, w_tmr_tc, w_size_ok;

  assign w_tmr_clr = (r_state != r_prev_state);
  assign w_tmr_en  = is_timed_state(r_state);
  assign w_size_ok = (buffer_occupancy <= 7'(MAX_PKT_BYTES));

  xact_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .i_clear (w_tmr_clr),
    .i_en    (w_tmr_en),
    .o_tc    (w_tmr_tc)
  );

  // Transaction FSM with registered pulse outputs and arm-flag bookkeeping.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= IDLE;
      r_prev_state <= IDLE;
      r_code       <= TX_NONE;
      r_tx_packet  <= TX_NONE;
      r_rx_armed   <= 1'b0;
      r_tx_armed   <= 1'b0;
      r_clear      <= 1'b0;
      r_rx_done    <= 1'b0;
      r_tx_done    <= 1'b0;
      r_xact_err   <= 1'b0;
    end else begin
      r_prev_state <= r_state;
      r_tx_packet  <= TX_NONE;
      r_clear      <= 1'b0;
      r_rx_done    <= 1'b0;
      r_tx_done    <= 1'b0;
      r_xact_err   <= 1'b0;
      if (abort) begin
        r_state <= IDLE;
        r_clear <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (rx_data_ready && (rx_packet == RX_OUT)) begin
              r_state <= WAIT_OUT_DATA;
            end else if (rx_data_ready && (rx_packet == RX_IN)) begin
              r_state     <= SEND;
              r_code      <= r_tx_armed ? TX_DATA : TX_NAK;
              r_tx_packet <= r_tx_armed ? TX_DATA : TX_NAK;
            end
          end
          WAIT_OUT_DATA: begin
            if (rx_data_ready) begin
              if (rx_error) begin
                r_state    <= IDLE;
                r_clear    <= 1'b1;
                r_xact_err <= 1'b1;
              end else if (rx_packet != RX_DATA) begin
                r_state    <= IDLE;
                r_xact_err <= 1'b1;
              end else if (r_rx_armed && w_size_ok) begin
                r_state     <= SEND;
                r_code      <= TX_ACK;
                r_tx_packet <= TX_ACK;
                r_rx_done   <= 1'b1;
                r_rx_armed  <= 1'b0;
              end else if (!r_rx_armed) begin
                r_state     <= SEND;
                r_code      <= TX_NAK;
                r_tx_packet <= TX_NAK;
                r_clear     <= 1'b1;
              end else begin
                r_state    <= IDLE;
                r_clear    <= 1'b1;
                r_xact_err <= 1'b1;
              end
            end else if (w_tmr_tc) begin
              r_state    <= IDLE;
              r_xact_err <= 1'b1;
            end
          end
          SEND: r_state <= WAIT_TX_START;
          WAIT_TX_START: begin
            if (tx_trans_active) begin
              r_state <= WAIT_TX_END;
            end else if (w_tmr_tc) begin
              r_state    <= IDLE;
              r_xact_err <= 1'b1;
            end
          end
          WAIT_TX_END: begin
            if (tx_error) begin
              r_state    <= IDLE;
              r_clear    <= 1'b1;
              r_xact_err <= 1'b1;
            end else if (!tx_trans_active) begin
              r_state <= (r_code == TX_DATA) ? WAIT_HOST_ACK : IDLE;
            end
          end
          WAIT_HOST_ACK: begin
            // A failed handshake keeps tx_armed so the host retry resends the same payload.
            if (rx_data_ready && !rx_error && (rx_packet == RX_ACK)) begin
              r_state    <= IDLE;
              r_tx_done  <= 1'b1;
              r_tx_armed <= 1'b0;
            end else if (rx_data_ready || w_tmr_tc) begin
              r_state    <= IDLE;
              r_xact_err <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
      // Later assignments override the auto-clear above: abort beats arm, arm beats auto-clear.
      if (abort) begin
        r_rx_armed <= 1'b0;
        r_tx_armed <= 1'b0;
      end else begin
        if (rx_arm) r_rx_armed <= 1'b1;
        if (tx_arm) r_tx_armed <= 1'b1;
      end
    end
  end

  assign tx_packet = r_tx_packet;
  assign clear     = r_clear;
  assign rx_done   = r_rx_done;
  assign tx_done   = r_tx_done;
  assign xact_err  = r_xact_err;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_usb_xact_ctrl.sv
// Table-driven bench for usb_xact_ctrl plus hand-written timeout and reset sequences.
module tb_usb_xact_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [3:0] rx_packet;
  logic       rx_data_ready, rx_error, tx_trans_active, tx_error;
  logic [6:0] buffer_occupancy;
  logic       rx_arm, tx_arm, abort;
  logic [3:0] tx_packet;
  logic       clear, rx_done, tx_done, xact_err, busy;

  int checks = 0;
  int errors = 0;

  usb_xact_ctrl dut (
    .clk(clk), .n_rst(n_rst), .rx_packet(rx_packet), .rx_data_ready(rx_data_ready),
    .rx_error(rx_error), .tx_trans_active(tx_trans_active), .tx_error(tx_error),
    .buffer_occupancy(buffer_occupancy), .rx_arm(rx_arm), .tx_arm(tx_arm), .abort(abort),
    .tx_packet(tx_packet), .clear(clear), .rx_done(rx_done), .tx_done(tx_done),
    .xact_err(xact_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pkt;
    logic       rdy, rerr, tact, terr;
    logic [6:0] occ;
    logic       rarm, tarm, abt;
    logic [8:0] exp;  // {tx_packet, clear, rx_done, tx_done, xact_err, busy}
  } vec_t;

  vec_t vq[$];
  int   row_base = 0;

  function automatic logic [8:0] ex(input logic [3:0] txp, input logic clr, input logic rxd,
                                    input logic txd, input logic err, input logic bsy);
    return {txp, clr, rxd, txd, err, bsy};
  endfunction

  function automatic void add(input logic [3:0] pkt, input logic rdy, input logic rerr,
                              input logic tact, input logic terr, input logic [6:0] occ,
                              input logic rarm, input logic tarm, input logic abt,
                              input logic [8:0] e);
    vec_t v;
    v.pkt = pkt; v.rdy = rdy; v.rerr = rerr; v.tact = tact; v.terr = terr;
    v.occ = occ; v.rarm = rarm; v.tarm = tarm; v.abt = abt; v.exp = e;
    vq.push_back(v);
  endfunction

  function automatic void nop(input logic tact, input logic bsy);
    add(4'd0, 1'b0, 1'b0, tact, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, ex(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, bsy));
  endfunction

  function automatic void strobe(input logic [3:0] pkt, input logic rerr, input logic [6:0] occ,
                                 input logic [8:0] e);
    add(pkt, 1'b1, rerr, 1'b0, 1'b0, occ, 1'b0, 1'b0, 1'b0, e);
  endfunction

  task automatic drive_idle();
    rx_packet = 4'd0; rx_data_ready = 1'b0; rx_error = 1'b0; tx_trans_active = 1'b0;
    tx_error = 1'b0; buffer_occupancy = 7'd0; rx_arm = 1'b0; tx_arm = 1'b0; abort = 1'b0;
  endtask

  task automatic check(input string nm, input int row, input logic [8:0] act, input logic [8:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s row %0d got txp=%0h clr/rxd/txd/err/busy=%05b want txp=%0h clr/rxd/txd/err/busy=%05b",
               nm, row, act[8:5], act[4:0], want[8:5], want[4:0]);
    end
  endtask

  task automatic run_vecs();
    foreach (vq[i]) begin
      @(negedge clk);
      rx_packet = vq[i].pkt; rx_data_ready = vq[i].rdy; rx_error = vq[i].rerr;
      tx_trans_active = vq[i].tact; tx_error = vq[i].terr; buffer_occupancy = vq[i].occ;
      rx_arm = vq[i].rarm; tx_arm = vq[i].tarm; abort = vq[i].abt;
      @(posedge clk);
      #1;
      check("vec", row_base + i, {tx_packet, clear, rx_done, tx_done, xact_err, busy}, vq[i].exp);
    end
    row_base += vq.size();
    vq.delete();
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    int k;
    drive_idle();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", -1, {tx_packet, clear, rx_done, tx_done, xact_err, busy}, 9'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // OUT armed: ACK with rx_done, 20 cycles of tx activity, back to idle
    add(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, ex(4'd0, 0, 0, 0, 0, 0));
    strobe(4'd1, 1'b0, 7'd0, ex(4'd0, 0, 0, 0, 0, 1));
    strobe(4'd3, 1'b0, 7'd8, ex(4'd2, 0, 1, 0, 0, 1));
    nop(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) nop(1'b1, 1'b1);
    nop(1'b0, 1'b0);
    // OUT not armed: NAK plus clear
    strobe(4'd1, 1'b0, 7'd0, ex(4'd0, 0, 0, 0, 0, 1));
    strobe(4'd3, 1'b0, 7'd8, ex(4'd3, 1, 0, 0, 0, 1));
    nop(1'b0, 1'b1); nop(1'b1, 1'b1); nop(1'b0, 1'b0);
    // IN armed: DATA, host ACK, tx_done; next IN gets NAK
    add(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, ex(4'd0, 0, 0, 0, 0, 0));
    strobe(4'd2, 1'b0, 7'd0, ex(4'd1, 0, 0, 0, 0, 1));
    nop(1'b0, 1'b1); nop(1'b1, 1'b1); nop(1'b1, 1'b1); nop(1'b0, 1'b1); nop(1'b0, 1'b1);
    strobe(4'd4, 1'b0, 7'd0, ex(4'd0, 0, 0, 1, 0, 0));
    strobe(4'd2, 1'b0, 7'd0, ex(4'd3, 0, 0, 0, 0, 1));
    nop(1'b0, 1'b1); nop(1'b1, 1'b1); nop(1'b0, 1'b0);
    // IN armed, then wait for an ACK that never comes
    add(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, ex(4'd0, 0, 0, 0, 0, 0));
    strobe(4'd2, 1'b0, 7'd0, ex(4'd1, 0, 0, 0, 0, 1));
    nop(1'b0, 1'b1); nop(1'b1, 1'b1); nop(1'b0, 1'b1);
    run_vecs();

    k = 0;
    for (int c = 1; c <= 1200; c++) begin
      @(posedge clk);
      #1;
      if (xact_err) begin
        k = c;
        break;
      end
    end
    checks++;
    if (k < 1020 || k > 1030) begin
      errors++;
      $display("FAIL host_ack_timeout got %0d cycles want 1020..1030", k);
    end
    check("timeout_idle", -2, {tx_packet, clear, rx_done, tx_done, 1'b0, busy}, 9'd0);

    // tx_armed survived the timeout: the retry sends DATA again
    strobe(4'd2, 1'b0, 7'd0, ex(4'd1, 0, 0, 0, 0, 1));
    nop(1'b0, 1'b1); nop(1'b1, 1'b1); nop(1'b0, 1'b1);
    strobe(4'd4, 1'b0, 7'd0, ex(4'd0, 0, 0, 1, 0, 0));
    // OUT errors: rx_error, oversize, then the 64-byte boundary accepted
    add(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, ex(4'd0, 0, 0, 0, 0, 0));
    strobe(4'd1, 1'b0, 7'd0, ex(4'd0, 0, 0, 0, 0, 1));
    strobe(4'd3, 1'b1, 7'd8, ex(4'd0, 1, 0, 0, 1, 0));
    strobe(4'd1, 1'b0, 7'd0, ex(4'd0, 0, 0, 0, 0, 1));
    strobe(4'd3, 1'b0, 7'd65, ex(4'd0, 1, 0, 0, 1, 0));
    strobe(4'd1, 1'b0, 7'd0, ex(4'd0, 0, 0, 0, 0, 1));
    strobe(4'd3, 1'b0, 7'd64, ex(4'd2, 0, 1, 0, 0, 1));
    nop(1'b0, 1'b1); nop(1'b1, 1'b1); nop(1'b0, 1'b0);
    strobe(4'd1, 1'b0, 7'd0, ex(4'd0, 0, 0, 0, 0, 1));
    strobe(4'd4, 1'b0, 7'd0, ex(4'd0, 0, 0, 0, 1, 0));
    // abort during WAIT_TX_END, then arm+abort in the same cycle
    add(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, ex(4'd0, 0, 0, 0, 0, 0));
    strobe(4'd2, 1'b0, 7'd0, ex(4'd1, 0, 0, 0, 0, 1));
    nop(1'b0, 1'b1); nop(1'b1, 1'b1);
    add(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b1, ex(4'd0, 1, 0, 0, 0, 0));
    nop(1'b0, 1'b0);
    strobe(4'd2, 1'b0, 7'd0, ex(4'd3, 0, 0, 0, 0, 1));
    nop(1'b0, 1'b1); nop(1'b1, 1'b1); nop(1'b0, 1'b0);
    add(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b1, ex(4'd0, 1, 0, 0, 0, 0));
    strobe(4'd2, 1'b0, 7'd0, ex(4'd3, 0, 0, 0, 0, 1));
    strobe(4'd2, 1'b0, 7'd0, ex(4'd0, 0, 0, 0, 0, 1));
    strobe(4'd2, 1'b0, 7'd0, ex(4'd0, 0, 0, 0, 0, 1));
    nop(1'b1, 1'b1); nop(1'b0, 1'b0);
    // tx_error during transmission
    strobe(4'd2, 1'b0, 7'd0, ex(4'd3, 0, 0, 0, 0, 1));
    nop(1'b0, 1'b1); nop(1'b1, 1'b1);
    add(4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd0, 1'b0, 1'b0, 1'b0, ex(4'd0, 1, 0, 0, 1, 0));
    // reach WAIT_HOST_ACK before the reset sequence
    add(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, ex(4'd0, 0, 0, 0, 0, 0));
    strobe(4'd2, 1'b0, 7'd0, ex(4'd1, 0, 0, 0, 0, 1));
    nop(1'b0, 1'b1); nop(1'b1, 1'b1); nop(1'b0, 1'b1);
    run_vecs();

    #2;
    n_rst = 1'b0;
    #1;
    check("async_reset", -3, {tx_packet, clear, rx_done, tx_done, xact_err, busy}, 9'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // tx_armed was reset, and IDLE ignores non-token strobes
    strobe(4'd2, 1'b0, 7'd0, ex(4'd3, 0, 0, 0, 0, 1));
    nop(1'b0, 1'b1); nop(1'b1, 1'b1); nop(1'b0, 1'b0);
    strobe(4'd3, 1'b0, 7'd8, ex(4'd0, 0, 0, 0, 0, 0));
    run_vecs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
